// File: rtl/readout_pkg.sv
// Shared types and constants for the image RAM readout path.
package readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned PIX_TOTAL = N_DEF * N_DEF;

    function automatic int unsigned pix_total(input int unsigned n);
        return n * n;
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO that buffers RAM read data for the pixel stream.
module readout_fifo
    import readout_pkg::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wp] <= din;
                r_wp        <= nxt(r_wp);
            end
            if (pop) begin
                r_rp <= nxt(r_rp);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

    assign dout  = r_mem[r_rp];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/image_readout.sv
// Sweeps the N*N image RAM in raster order and streams pixels over valid/ready
// with row-end and frame-end markers; a credit check keeps the FIFO from overflowing.
module image_readout
    import readout_pkg::*;
#(
    parameter int unsigned N          = N_DEF,
    parameter int unsigned bitSize    = $clog2(N * N),
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [bitSize-1:0] rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               out_eol
);

    localparam int unsigned PIX = pix_total(N);
    localparam int unsigned CB  = $clog2(N);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

    state_t             r_state;
    logic [bitSize-1:0] r_addr;
    logic               r_pend;
    logic [bitSize:0]   r_pix;
    logic [CB-1:0]      r_col;
    logic [CB-1:0]      r_row;

    logic [FCW-1:0]     w_count;
    logic               w_empty;
    logic               w_full;
    logic [DATA_W-1:0]  w_head;
    logic               w_rd;
    logic               w_xfer;
    logic               w_last;
    logic               w_addr_end;

    // A read in flight owns a FIFO slot, so it counts against the space.
    assign w_rd       = (r_state == READ) && ((32'(w_count) + 32'(r_pend)) < FIFO_DEPTH);
    assign w_xfer     = !w_empty && out_ready;
    assign w_last     = (r_pix == (bitSize + 1)'(PIX - 1));
    assign w_addr_end = (r_addr == bitSize'(PIX - 1));

    readout_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_pend),
        .pop   (w_xfer),
        .din   (rd_data),
        .dout  (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_pend  <= 1'b0;
            r_pix   <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_pend <= w_rd;
            // Address holds at the last pixel instead of wrapping within a frame.
            if (w_rd && !w_addr_end) begin
                r_addr <= r_addr + bitSize'(1);
            end
            if (w_xfer) begin
                r_pix <= r_pix + (bitSize + 1)'(1);
                if (r_col == CB'(N - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + CB'(1);
                end else begin
                    r_col <= r_col + CB'(1);
                end
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= READ;
                        r_addr  <= '0;
                        r_pix   <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                READ:    if (w_rd && w_addr_end) r_state <= DRAIN;
                DRAIN:   if (w_xfer && w_last) r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_xfer && w_last) begin
            assert (r_row == CB'(N - 1) && r_col == CB'(N - 1));
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign rd_en     = w_rd;
    assign rd_addr   = r_addr;
    assign out_valid = !w_empty;
    assign out_data  = w_head;
    assign out_eol   = !w_empty && (r_col == CB'(N - 1));
    assign out_last  = !w_empty && w_last;

endmodule

// File: tb/tb_image_readout.sv
// Directed bench for image_readout: full-rate frame, backpressure, restart and reset cases.
module tb_image_readout;

    localparam int unsigned N  = 8;
    localparam int unsigned BS = 6;
    localparam int unsigned DW = 8;
    localparam int unsigned FD = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, done, rd_en, out_valid, out_last, out_eol;
    logic [BS-1:0] rd_addr;
    logic [DW-1:0] rd_data, out_data;
    logic [DW-1:0] mem [N*N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    image_readout #(
        .N          (N),
        .bitSize    (BS),
        .DATA_W     (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_eol   (out_eol)
    );

    // RAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int occ();
        return int'(dut.w_count) + int'(dut.r_pend);
    endfunction

    task automatic idle_check(input string p);
        int nd, nb;
        nd = 0;
        nb = 0;
        out_ready = 1'b1;
        repeat (10) begin
            tick();
            if (done) nd++;
            if (busy) nb++;
        end
        check({p, "_idle_done"}, nd, 0);
        check({p, "_idle_busy"}, nb, 0);
    endtask

    // mode: 0 ready high, 1 ready toggling, 2 stall after pixel 20,
    //       3 start re-pulsed at pixel 30, 4 reset at pixel 40
    task automatic run_frame(input int mode, input string p);
        int idx, errs, first, lastc, donec, ndone, maxocc, viol, lat;
        bit stalled, rchk;
        idx = 0; errs = 0; first = -1; lastc = -1; donec = -1;
        ndone = 0; maxocc = 0; viol = 0; lat = -1; stalled = 0; rchk = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (donec >= 0 && cyc == donec + 1) break;
            start = 1'b0;
            if (mode == 2 && idx == 21 && !stalled) begin
                stalled   = 1;
                out_ready = 1'b0;
                repeat (10) tick();
                check({p, "_stall_valid"}, out_valid, 1);
                check({p, "_stall_data"}, out_data, 21);
                check({p, "_stall_occ"}, occ(), 3);
                check({p, "_stall_rden"}, rd_en, 0);
            end
            if (mode == 2 && stalled && idx == 22 && !rchk) begin
                rchk = 1;
                check({p, "_resume_rden"}, rd_en, 1);
            end
            if (mode == 3 && idx == 30) start = 1'b1;
            if (mode == 4 && idx == 40) begin
                rst_n = 1'b0;
                #1;
                check({p, "_rst_ctrl"}, {out_valid, busy, rd_en, done, out_last, out_eol}, 0);
                check({p, "_rst_data"}, out_data, 0);
                check({p, "_pre_rst_errs"}, errs, 0);
                return;
            end
            out_ready = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
            if (lat < 0 && out_valid) lat = cyc;
            if (occ() > maxocc) maxocc = occ();
            if (rd_en && occ() >= int'(FD)) viol++;
            if (done) begin
                ndone++;
                donec = cyc;
            end
            if (out_valid && out_ready) begin
                if (out_data !== DW'(idx) || out_eol !== (idx % N == N - 1) ||
                    out_last !== (idx == N * N - 1)) errs++;
                if (first < 0) first = cyc;
                lastc = cyc;
                idx++;
            end
            tick();
        end
        check({p, "_xfers"}, idx, N * N);
        check({p, "_errs"}, errs, 0);
        check({p, "_ndone"}, ndone, 1);
        check({p, "_done_gap"}, donec - lastc, 1);
        check({p, "_busy_end"}, busy, 0);
        check({p, "_maxocc_le3"}, maxocc <= int'(FD), 1);
        check({p, "_rd_viol"}, viol, 0);
        if (mode == 0) begin
            check({p, "_latency"}, lat, 2);
            check({p, "_span"}, lastc - first, N * N - 1);
        end
    endtask

    initial begin
        int nrd, nact;
        for (int i = 0; i < int'(N * N); i++) mem[i] = DW'(i);

        #1;
        check("reset_ctrl", {out_valid, busy, rd_en, done, out_last, out_eol}, 0);
        check("reset_data", out_data, 0);
        check("reset_addr", rd_addr, 0);
        tick();
        rst_n = 1'b1;
        nrd = 0;
        nact = 0;
        repeat (20) begin
            tick();
            if (rd_en) nrd++;
            if (out_valid || busy || done) nact++;
        end
        check("idle_rden", nrd, 0);
        check("idle_active", nact, 0);

        run_frame(0, "full");
        idle_check("full");
        run_frame(1, "toggle");
        idle_check("toggle");
        run_frame(2, "stall");
        idle_check("stall");
        run_frame(3, "restart");
        idle_check("restart");
        run_frame(4, "reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);
        run_frame(0, "replay");
        idle_check("replay");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
